// File: rtl/carregador_programa.sv
// Program loader: copies a program image from the HD into instruction memory,
// holds the core in reset while loading, then serves instructions by PC.
module carregador_programa #(
    parameter int unsigned ADDR_W    = 6,
    parameter int unsigned HD_ADDR_W = 10,
    parameter logic [31:0] NOP_WORD  = 32'h00000013
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [3:0]           prog_id,
    input  logic [ADDR_W:0]      prog_len,
    output logic                 hd_rd,
    output logic [HD_ADDR_W-1:0] hd_addr,
    input  logic [31:0]          hd_data,
    input  logic [31:0]          atualPC,
    output logic [31:0]          inst,
    input  logic                 HALT,
    output logic                 cpu_reset,
    output logic                 busy,
    output logic [ADDR_W:0]      loaded_words
);

    localparam int unsigned     DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE     = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StHalted} state_t;

    state_t                 r_state;
    logic [31:0]            r_mem [DEPTH];
    logic [ADDR_W:0]        r_n;
    logic [HD_ADDR_W-1:0]   r_base;
    logic [ADDR_W:0]        r_rd_cnt;
    logic [ADDR_W:0]        r_wr_cnt;
    logic                   r_wr_pend;
    logic                   r_hd_rd;
    logic [HD_ADDR_W-1:0]   r_hd_addr;
    logic                   r_cpu_reset;
    logic                   r_busy;
    logic [ADDR_W:0]        r_loaded_words;

    logic [HD_ADDR_W+3:0]   w_base_full;
    logic [HD_ADDR_W-1:0]   w_base;
    logic [ADDR_W:0]        w_n;
    logic                   w_accept;
    logic                   w_mem_we;
    logic [ADDR_W:0]        w_wr_cnt_nxt;
    logic                   w_unused_pc;

    assign w_base_full  = {{HD_ADDR_W{1'b0}}, prog_id} << ADDR_W;
    assign w_base       = w_base_full[HD_ADDR_W-1:0];
    assign w_n          = (prog_len > MAX_LEN) ? MAX_LEN : prog_len;
    assign w_accept     = start && (r_state != StLoad);
    assign w_wr_cnt_nxt = r_wr_cnt + ONE;
    // hd_data answers the read issued one cycle earlier
    assign w_mem_we     = (r_state == StLoad) && r_wr_pend && !reset;
    assign w_unused_pc  = ^atualPC[31:ADDR_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= StIdle;
            r_n            <= '0;
            r_base         <= '0;
            r_rd_cnt       <= '0;
            r_wr_cnt       <= '0;
            r_wr_pend      <= 1'b0;
            r_hd_rd        <= 1'b0;
            r_hd_addr      <= '0;
            r_cpu_reset    <= 1'b1;
            r_busy         <= 1'b0;
            r_loaded_words <= '0;
        end else if (w_accept) begin
            r_n            <= w_n;
            r_base         <= w_base;
            r_wr_cnt       <= '0;
            r_wr_pend      <= 1'b0;
            r_loaded_words <= '0;
            if (w_n == '0) begin
                r_state     <= StRun;
                r_rd_cnt    <= '0;
                r_hd_rd     <= 1'b0;
                r_cpu_reset <= 1'b0;
                r_busy      <= 1'b0;
            end else begin
                // first read goes out in LOAD cycle 0, so it is issued here
                r_state     <= StLoad;
                r_rd_cnt    <= ONE;
                r_hd_rd     <= 1'b1;
                r_hd_addr   <= w_base;
                r_cpu_reset <= 1'b1;
                r_busy      <= 1'b1;
            end
        end else begin
            case (r_state)
                StIdle: begin
                    r_cpu_reset <= 1'b1;
                end
                StLoad: begin
                    if (r_rd_cnt < r_n) begin
                        r_hd_rd   <= 1'b1;
                        r_hd_addr <= r_base + HD_ADDR_W'(r_rd_cnt[ADDR_W-1:0]);
                        r_rd_cnt  <= r_rd_cnt + ONE;
                    end else begin
                        r_hd_rd <= 1'b0;
                    end
                    r_wr_pend <= r_hd_rd;
                    if (r_wr_pend) begin
                        r_wr_cnt       <= w_wr_cnt_nxt;
                        r_loaded_words <= r_loaded_words + ONE;
                        if (w_wr_cnt_nxt == r_n) begin
                            r_state     <= StRun;
                            r_cpu_reset <= 1'b0;
                            r_busy      <= 1'b0;
                            r_hd_rd     <= 1'b0;
                        end
                    end
                end
                StRun: begin
                    if (HALT) begin
                        r_state <= StHalted;
                    end
                end
                default: begin
                    r_state <= StHalted;
                end
            endcase
        end
    end

    // No reset: contents survive reset and are only replaced by a load
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_wr_cnt[ADDR_W-1:0]] <= hd_data;
        end
    end

    assign inst         = (r_state == StRun) ? r_mem[atualPC[ADDR_W-1:0]] : NOP_WORD;
    assign hd_rd        = r_hd_rd;
    assign hd_addr      = r_hd_addr;
    assign cpu_reset    = r_cpu_reset;
    assign busy         = r_busy;
    assign loaded_words = r_loaded_words;

endmodule
